// File: rtl/ch9350_ledtx_if.sv
// Byte stream from the LED frame builder to the UART transmitter.
// Latency: none, wires only.
// Backpressure: the consumer throttles the producer with i_byte_ready (AXI-stream style).
//
// Signals:
//   o_byte        8  frame byte (s_axis_tdata of the UART TX)
//   o_byte_valid  1  o_byte is valid (s_axis_tvalid)
//   i_byte_ready  1  UART TX accepts the byte this cycle (s_axis_tready)
//   o_busy        1  a frame is in flight
interface ch9350_ledtx_if;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       i_byte_ready;
    logic       o_busy;

    // master: the frame builder; slave: the UART TX side
    modport master (
        output o_byte,
        output o_byte_valid,
        output o_busy,
        input  i_byte_ready
    );

    modport slave (
        input  o_byte,
        input  o_byte_valid,
        input  o_busy,
        output i_byte_ready
    );
endinterface

// File: rtl/ch9350_ledtx.sv
// Host->CH9350 LED/status frame transmitter: 8-byte frames on LED change and on keep-alive.
// Latency: first byte valid the cycle after the trigger is seen; one byte per accepted handshake.
// Backpressure: byte held stable while i_byte_ready is low; no new frame starts until the current one ends.
//
// Ports:
//   i_clk   in   system clock (12 MHz)
//   rst     in   synchronous reset, active-high
//   i_leds  in   level LED state: [0] num, [1] caps, [2] scroll
//   tx      master side of ch9350_ledtx_if (o_byte, o_byte_valid, i_byte_ready, o_busy)
//
// Frame: 57 AB CMD {5'b0,LED} SEQ 00 00 CKSUM, CKSUM = CMD + LED + SEQ (mod 256).
module ch9350_ledtx #(
    parameter int unsigned KEEPALIVE_CYCLES = 12_000_000,
    parameter logic [7:0]  CMD              = 8'h12
) (
    input  logic            i_clk,
    input  logic            rst,
    input  logic [2:0]      i_leds,
    ch9350_ledtx_if.master  tx
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Keep-alive is disabled entirely when the period is zero.
    localparam bit          KA_EN   = (KEEPALIVE_CYCLES != 0);
    localparam logic [31:0] KA_LAST = KA_EN ? 32'(KEEPALIVE_CYCLES - 1) : 32'd0;

    state_t      state_q, state_nxt;
    logic [2:0]  idx_q, idx_nxt;
    logic [7:0]  seq_q, seq_nxt;
    logic [2:0]  sent_led_q, sent_led_nxt;
    logic [2:0]  led_q, led_nxt;
    logic [31:0] timer_q, timer_nxt;
    logic [7:0]  byte_q, byte_nxt;
    logic        vld_q, vld_nxt;
    logic        busy_q, busy_nxt;

    logic        ka_hit;
    logic        trigger;
    logic        xfer;

    // Byte at position idx of a frame carrying the given LED snapshot and sequence number.
    function automatic logic [7:0] frame_byte(
        input logic [2:0] idx,
        input logic [2:0] led,
        input logic [7:0] seq
    );
        logic [7:0] led_byte;
        led_byte = {5'b00000, led};
        case (idx)
            3'd0:    frame_byte = 8'h57;
            3'd1:    frame_byte = 8'hAB;
            3'd2:    frame_byte = CMD;
            3'd3:    frame_byte = led_byte;
            3'd4:    frame_byte = seq;
            3'd5:    frame_byte = 8'h00;
            3'd6:    frame_byte = 8'h00;
            default: frame_byte = CMD + led_byte + seq;
        endcase
    endfunction

    assign ka_hit  = KA_EN && (timer_q == KA_LAST);
    // Only compared in IDLE, so LED wiggles that settle back before the frame ends are ignored.
    assign trigger = (i_leds != sent_led_q) || ka_hit;
    assign xfer    = vld_q && tx.i_byte_ready;

    always_comb begin
        state_nxt    = state_q;
        idx_nxt      = idx_q;
        seq_nxt      = seq_q;
        sent_led_nxt = sent_led_q;
        led_nxt      = led_q;
        byte_nxt     = byte_q;
        vld_nxt      = vld_q;
        busy_nxt     = busy_q;

        // The timer free-runs in both states and wraps on expiry; an expiry seen
        // mid-frame is therefore simply lost, which is the intended behaviour.
        if (!KA_EN || ka_hit) begin
            timer_nxt = 32'd0;
        end else begin
            timer_nxt = timer_q + 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_nxt    = SEND;
                    idx_nxt      = 3'd0;
                    led_nxt      = i_leds;
                    sent_led_nxt = i_leds;
                    byte_nxt     = frame_byte(3'd0, i_leds, seq_q);
                    vld_nxt      = 1'b1;
                    busy_nxt     = 1'b1;
                    timer_nxt    = 32'd0;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == 3'd7) begin
                        state_nxt = IDLE;
                        vld_nxt   = 1'b0;
                        busy_nxt  = 1'b0;
                        seq_nxt   = seq_q + 8'd1;
                    end else begin
                        idx_nxt  = idx_q + 3'd1;
                        byte_nxt = frame_byte(idx_q + 3'd1, led_q, seq_q);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                vld_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            seq_q      <= 8'd0;
            sent_led_q <= 3'b000;
            led_q      <= 3'b000;
            timer_q    <= 32'd0;
            byte_q     <= 8'd0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            idx_q      <= idx_nxt;
            seq_q      <= seq_nxt;
            sent_led_q <= sent_led_nxt;
            led_q      <= led_nxt;
            timer_q    <= timer_nxt;
            byte_q     <= byte_nxt;
            vld_q      <= vld_nxt;
            busy_q     <= busy_nxt;
        end
    end

    assign tx.o_byte       = byte_q;
    assign tx.o_byte_valid = vld_q;
    assign tx.o_busy       = busy_q;

    // A stalled byte must not move or disappear.
    a_stall_hold: assert property (@(posedge i_clk) disable iff (rst)
        (tx.o_byte_valid && !tx.i_byte_ready) |=> (tx.o_byte_valid && $stable(tx.o_byte)));

    // busy spans exactly the cycles in which a frame byte is being offered.
    a_busy_vld: assert property (@(posedge i_clk) disable iff (rst)
        tx.o_busy == tx.o_byte_valid);

endmodule

// File: tb/tb_ch9350_ledtx.sv
// Bench for ch9350_ledtx: one instance without keep-alive, one with a 100-cycle keep-alive.
// Expected frames are queued when stimulus is applied and compared on every accepted byte.
module tb_ch9350_ledtx;

    logic       clk = 1'b0;
    logic       rst0;
    logic       rst1;
    logic [2:0] leds0;
    logic [2:0] leds1;

    always #5 clk = ~clk;

    ch9350_ledtx_if bus0();
    ch9350_ledtx_if bus1();

    ch9350_ledtx #(.KEEPALIVE_CYCLES(0), .CMD(8'h12)) dut (
        .i_clk  (clk),
        .rst    (rst0),
        .i_leds (leds0),
        .tx     (bus0.master)
    );

    ch9350_ledtx #(.KEEPALIVE_CYCLES(100), .CMD(8'h12)) dut_ka (
        .i_clk  (clk),
        .rst    (rst1),
        .i_leds (leds1),
        .tx     (bus1.master)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         xfer0  = 0;
    int         xfer1  = 0;
    int         vcyc0  = 0;
    int         st1[$];
    logic [7:0] ring1[16];
    logic       stall0_q = 1'b0;
    logic [7:0] stall0_b = 8'd0;
    logic [7:0] seq0;
    logic [7:0] seq1;
    bit         done1  = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void push_frame(input int which, input logic [2:0] led, input logic [7:0] seq);
        logic [7:0] f[8];
        logic [7:0] ck;
        ck = 8'h12 + {5'b00000, led} + seq;
        f  = '{8'h57, 8'hAB, 8'h12, {5'b00000, led}, seq, 8'h00, 8'h00, ck};
        for (int i = 0; i < 8; i++) begin
            if (which == 0) q0.push_back(f[i]);
            else            q1.push_back(f[i]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard / monitor for the instance without keep-alive.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst0) begin
            if (bus0.o_byte_valid) vcyc0++;
            if (stall0_q) begin
                chk_eq("stall_vld", 32'(bus0.o_byte_valid), 32'd1);
                chk_eq("stall_byte", 32'(bus0.o_byte), 32'(stall0_b));
            end
            if (bus0.o_byte_valid && bus0.i_byte_ready) begin
                if (q0.size() > 0) e = 32'(q0.pop_front());
                else               e = 32'h1FF;
                chk_eq("byte0", 32'(bus0.o_byte), e);
                xfer0++;
            end
            stall0_q = bus0.o_byte_valid && !bus0.i_byte_ready;
            stall0_b = bus0.o_byte;
        end else begin
            stall0_q = 1'b0;
        end
    end

    // Scoreboard / monitor for the keep-alive instance; records frame start cycles.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst1 && bus1.o_byte_valid && bus1.i_byte_ready) begin
            if (xfer1 % 8 == 0) st1.push_back(cyc);
            ring1[xfer1 % 16] = bus1.o_byte;
            if (q1.size() > 0) e = 32'(q1.pop_front());
            else               e = 32'h1FF;
            chk_eq("byte1", 32'(bus1.o_byte), e);
            xfer1++;
        end
    end

    // Instance without keep-alive: reset, latency, stalls, back-to-back, boundaries.
    initial begin
        int base;
        rst0  = 1'b1;
        leds0 = 3'b000;
        bus0.i_byte_ready = 1'b1;
        seq0  = 8'd0;
        repeat (3) tick();
        chk_eq("rst_vld",  32'(bus0.o_byte_valid), 32'd0);
        chk_eq("rst_busy", 32'(bus0.o_busy), 32'd0);
        chk_eq("rst_byte", 32'(bus0.o_byte), 32'd0);
        rst0 = 1'b0;
        repeat (1000) tick();
        chk_eq("idle_vld",  32'(vcyc0), 32'd0);
        chk_eq("idle_xfer", 32'(xfer0), 32'd0);

        // LED change 000->010 with ready held high
        base  = xfer0;
        leds0 = 3'b010;
        push_frame(0, 3'b010, seq0); seq0++;
        tick();
        chk_eq("lat_vld",  32'(bus0.o_byte_valid), 32'd1);
        chk_eq("lat_byte", 32'(bus0.o_byte), 32'h57);
        chk_eq("lat_busy", 32'(bus0.o_busy), 32'd1);
        repeat (7) tick();
        chk_eq("last_vld",  32'(bus0.o_byte_valid), 32'd1);
        chk_eq("last_byte", 32'(bus0.o_byte), 32'h14);
        tick();
        chk_eq("end_busy", 32'(bus0.o_busy), 32'd0);
        chk_eq("end_vld",  32'(bus0.o_byte_valid), 32'd0);
        chk_eq("frame_xfers", 32'(xfer0 - base), 32'd8);

        // Ready toggling every cycle
        repeat (5) tick();
        leds0 = 3'b000;
        push_frame(0, 3'b000, seq0); seq0++;
        repeat (12) tick();
        base  = xfer0;
        leds0 = 3'b010;
        push_frame(0, 3'b010, seq0); seq0++;
        for (int i = 0; i < 40; i++) begin
            bus0.i_byte_ready = ~bus0.i_byte_ready;
            tick();
        end
        bus0.i_byte_ready = 1'b1;
        tick();
        chk_eq("stall_xfers", 32'(xfer0 - base), 32'd8);
        chk_eq("stall_qempty", 32'(q0.size()), 32'd0);

        // LED change during byte 3 -> second frame right after the first
        repeat (3) tick();
        base  = xfer0;
        leds0 = 3'b001;
        push_frame(0, 3'b001, seq0); seq0++;
        repeat (4) tick();
        leds0 = 3'b101;
        push_frame(0, 3'b101, seq0); seq0++;
        repeat (25) tick();
        chk_eq("b2b_xfers", 32'(xfer0 - base), 32'd16);
        chk_eq("b2b_qempty", 32'(q0.size()), 32'd0);

        // LED toggles and returns to the sent value mid-frame -> only one frame
        base  = xfer0;
        leds0 = 3'b100;
        push_frame(0, 3'b100, seq0); seq0++;
        repeat (2) tick();
        leds0 = 3'b110;
        repeat (2) tick();
        leds0 = 3'b100;
        repeat (25) tick();
        chk_eq("toggle_xfers", 32'(xfer0 - base), 32'd8);

        // Ready stuck low holds byte 0
        base = xfer0;
        bus0.i_byte_ready = 1'b0;
        leds0 = 3'b011;
        push_frame(0, 3'b011, seq0); seq0++;
        repeat (50) tick();
        chk_eq("stuck_vld",  32'(bus0.o_byte_valid), 32'd1);
        chk_eq("stuck_byte", 32'(bus0.o_byte), 32'h57);
        chk_eq("stuck_xfer", 32'(xfer0 - base), 32'd0);
        bus0.i_byte_ready = 1'b1;
        repeat (20) tick();
        chk_eq("stuck_done", 32'(xfer0 - base), 32'd8);

        // Reset mid-frame aborts the frame and clears SEQ
        leds0 = 3'b111;
        push_frame(0, 3'b111, seq0);
        repeat (3) tick();
        rst0  = 1'b1;
        leds0 = 3'b000;
        tick();
        chk_eq("rstm_vld",  32'(bus0.o_byte_valid), 32'd0);
        chk_eq("rstm_busy", 32'(bus0.o_busy), 32'd0);
        chk_eq("rstm_byte", 32'(bus0.o_byte), 32'd0);
        q0.delete();
        seq0 = 8'd0;
        rst0 = 1'b0;
        base = xfer0;
        repeat (20) tick();
        chk_eq("post_rst_idle", 32'(xfer0 - base), 32'd0);
        leds0 = 3'b110;
        push_frame(0, 3'b110, seq0); seq0++;
        repeat (12) tick();
        chk_eq("post_rst_xfer", 32'(xfer0 - base), 32'd8);
        chk_eq("post_rst_qempty", 32'(q0.size()), 32'd0);

        while (!done1) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Keep-alive instance: SEQ wrap over 257 frames, then 100-cycle period with LED 011.
    initial begin
        int g;
        int n;
        rst1  = 1'b1;
        leds1 = 3'b000;
        bus1.i_byte_ready = 1'b1;
        seq1  = 8'd0;
        repeat (3) tick();
        rst1 = 1'b0;
        for (int i = 0; i < 257; i++) begin
            push_frame(1, 3'b000, seq1);
            seq1++;
        end
        g = 0;
        while (xfer1 < 2056 && g < 27000) begin
            tick();
            g++;
        end
        chk_eq("ka_frames", 32'(xfer1), 32'd2056);
        chk_eq("seq_256",  32'(ring1[12]), 32'hFF);
        chk_eq("ck_256",   32'(ring1[15]), 32'h11);
        chk_eq("seq_257",  32'(ring1[4]),  32'h00);
        chk_eq("ck_257",   32'(ring1[7]),  32'h12);
        for (int k = 1; k < 5; k++) begin
            chk_eq("ka_period", 32'(st1[k] - st1[k-1]), 32'd100);
        end

        n     = st1.size();
        leds1 = 3'b011;
        for (int i = 0; i < 4; i++) begin
            push_frame(1, 3'b011, seq1);
            seq1++;
        end
        g = 0;
        while (xfer1 < 2056 + 32 && g < 500) begin
            tick();
            g++;
        end
        rst1 = 1'b1;
        chk_eq("ka_led_frames", 32'(xfer1), 32'd2088);
        chk_eq("ka_qempty", 32'(q1.size()), 32'd0);
        for (int k = n + 1; k < n + 4; k++) begin
            chk_eq("ka_period_led", 32'(st1[k] - st1[k-1]), 32'd100);
        end
        done1 = 1'b1;
    end

endmodule
